dmem_pipe: RTL and testbench
============================

// Module: dmem_pipe
// PURPOSE
// - Parametrised single-port data memory with byte-enabled writes and pipelined reads.
// - Request and response channels use valid/ready handshakes.
// - Read latency is configurable; an in-order response FIFO absorbs back-pressure.
// - A credit counter ensures an accepted read always has a response slot, so the pipeline never stalls.
// - Sits between core load/store unit and local data RAM.
// PARAMETERS
// ADDR_W      10  word address width; depth = 2**ADDR_W words
// DATA_W      32  word width; multiple of 8; BE_W = DATA_W/8
// READ_LAT    1   cycles from read accept to data entering response FIFO; 1..4
// RESP_DEPTH  4   response FIFO depth; >= READ_LAT; power of two
// TAG_W       4   request tag width; returned with read data
// PORTS
// i_clk          in   1       clock, all logic on rising edge
// i_rst          in   1       synchronous reset, active-high
// in_req_valid   in   1       request valid
// out_req_ready  out  1       request accepted when valid && ready
// in_req_we      in   1       1 = write, 0 = read
// in_req_addr    in   ADDR_W  word address
// in_req_wdata   in   DATA_W  write data
// in_req_be      in   BE_W    byte enables (writes only)
// in_req_tag     in   TAG_W   read tag
// out_rsp_valid  out  1       read response valid
// in_rsp_ready   in   1       response consumed when valid && ready
// out_rsp_data   out  DATA_W  read data
// out_rsp_tag    out  TAG_W   tag of the originating read
// BEHAVIOUR
// - Reset (sync, i_rst high at edge):
//   - clears pipeline valids, FIFO pointers and credit count.
//   - Memory contents are NOT reset.
//   - Next cycle: out_req_ready=1, out_rsp_valid=0, out_rsp_data=0, out_rsp_tag=0.
//   - In-flight reads are discarded, with no response.
// - Write accept (valid && ready && we):
//   - At that edge, byte k of mem[addr] takes wdata byte k if be[k]=1, otherwise it keeps its old value.
//   - be=0 is a legal no-op write.
//   - Writes produce no response and consume no credit.
// - Read accept (valid && ready && !we):
//   - Samples mem[addr] at the accept edge.
//   - {data,tag} travels through READ_LAT pipeline stages (stage 1 = accept edge).
//   - Pushed into FIFO at the end of stage READ_LAT; visible on out_rsp_* the following cycle at the earliest.
//   - Minimum accept-to-out_rsp_valid latency = READ_LAT cycles.
// - Ordering: one request per cycle.
//   - Read of an address written in the previous cycle returns the new data.
//   - Responses are strictly in accept order.
// - Credit counter cnt (0..RESP_DEPTH) = reads in pipeline + FIFO entries:
//   - +1 on read accept; -1 on response pop; both in one cycle -> unchanged.
//   - out_req_ready = (cnt < RESP_DEPTH); driven from registers only, no combinational path from in_req_*.
//   - Ready gates writes too: uniform rule, no per-type bypass.
// - FIFO is first-word-fall-through:
//   - out_rsp_valid = !empty.
//   - out_rsp_data/tag forced to 0 while !out_rsp_valid.
//   - Data/tag must remain stable while valid && !ready.
// - Boundaries:
//   - Full (cnt == RESP_DEPTH): ready=0.
//   - Pop at full: ready=1 next cycle.
//   - Pointers wrap modulo RESP_DEPTH.
//   - Pipeline stages never stall; credits guarantee FIFO space.
//   - Push and pop in the same cycle on an empty FIFO: the pushed entry becomes valid next cycle; no bypass.
// TESTING
// - Byte enables: write 0xAABBCCDD @0x010 be=1111, then write 0x11223344 be=0011, read @0x010 -> data 0xAABB3344.
// - Latency: READ_LAT=2, read @5 tag=3 accepted in cycle t, rsp_ready=1 -> out_rsp_valid first high at t+2, tag=3.
// - Back-pressure: rsp_ready=0, issue RESP_DEPTH reads -> ready=0 after the 4th accept.
//   - Then pop one -> ready=1 next cycle; the 5th read completes.
//   - All data in order.
// - Simultaneous: at cnt=RESP_DEPTH-1, accept a read and pop in the same cycle -> cnt unchanged, ready stays 1.
// - RAW: write 0xDEADBEEF @7 in cycle t, read @7 in cycle t+1 -> response 0xDEADBEEF.
// - Reset mid-operation: two reads in flight, i_rst for one cycle.
//   - No responses, ready=1, outputs 0.
//   - Memory still holds prior writes on read-back.

Source files
------------

// File: rtl/dmem_pipe.sv
// Single-port data memory with byte-enabled writes, a fixed-latency read pipeline
// and an in-order first-word-fall-through response FIFO guarded by read credits.
module dmem_pipe #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 1,
  parameter int RESP_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic                  in_req_we,
  input  logic [ADDR_W-1:0]     in_req_addr,
  input  logic [DATA_W-1:0]     in_req_wdata,
  input  logic [DATA_W/8-1:0]   in_req_be,
  input  logic [TAG_W-1:0]      in_req_tag,
  output logic                  out_rsp_valid,
  input  logic                  in_rsp_ready,
  output logic [DATA_W-1:0]     out_rsp_data,
  output logic [TAG_W-1:0]      out_rsp_tag
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
  // ready never depends combinationally on valid or payload of the same channel.
  logic req_acc, wr_acc, rd_acc, pop;
  logic [DATA_W-1:0] rd_word;

  assign req_acc = in_req_valid && out_req_ready;
  assign wr_acc  = req_acc && in_req_we;
  assign rd_acc  = req_acc && !in_req_we;
  assign pop     = out_rsp_valid && in_rsp_ready;

  // Memory array: never reset, written byte-wise
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int k = 0; k < BE_W; k++) begin
        if (in_req_be[k]) mem_q[in_req_addr][8*k +: 8] <= in_req_wdata[8*k +: 8];
      end
    end
  end

  assign rd_word = mem_q[in_req_addr];

  // Read pipeline: the accept edge is stage 1, FIFO push happens at the end of stage READ_LAT
  logic              push_v;
  logic [DATA_W-1:0] push_d;
  logic [TAG_W-1:0]  push_t;

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign push_v = rd_acc;
      assign push_d = rd_word;
      assign push_t = in_req_tag;
    end else begin : g_pipe
      localparam int NS = READ_LAT - 1;
      logic [NS-1:0]     v_q;
      logic [DATA_W-1:0] d_q [NS];
      logic [TAG_W-1:0]  t_q [NS];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          v_q <= '0;
        end else begin
          for (int i = NS - 1; i > 0; i--) v_q[i] <= v_q[i-1];
          v_q[0] <= rd_acc;
        end
      end

      always_ff @(posedge i_clk) begin
        for (int i = NS - 1; i > 0; i--) begin
          d_q[i] <= d_q[i-1];
          t_q[i] <= t_q[i-1];
        end
        d_q[0] <= rd_word;
        t_q[0] <= in_req_tag;
      end

      assign push_v = v_q[NS-1];
      assign push_d = d_q[NS-1];
      assign push_t = t_q[NS-1];
    end
  endgenerate

  // Response FIFO
  logic [DATA_W-1:0] fd_q [RESP_DEPTH];
  logic [TAG_W-1:0]  ft_q [RESP_DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    fcnt_d = fcnt_q;
    if (push_v) wp_d = (wp_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wp_q + 1'b1;
    if (pop)    rp_d = (rp_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rp_q + 1'b1;
    if (push_v && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!push_v && pop) fcnt_d = fcnt_q - 1'b1;
  end

  // Credits cover every read between accept and pop, so a push always finds room
  always_comb begin
    cnt_d = cnt_q;
    if (rd_acc && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!rd_acc && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      fcnt_q <= fcnt_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_v) begin
      fd_q[wp_q] <= push_d;
      ft_q[wp_q] <= push_t;
    end
  end

  assign out_req_ready = (cnt_q < CNT_W'(RESP_DEPTH));
  assign out_rsp_valid = (fcnt_q != '0);
  assign out_rsp_data  = out_rsp_valid ? fd_q[rp_q] : '0;
  assign out_rsp_tag   = out_rsp_valid ? ft_q[rp_q] : '0;

endmodule

// File: tb/tb_dmem_pipe.sv
// Bench for dmem_pipe: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (array memory + in-order expected-response queue).
module tb_dmem_pipe;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int READ_LAT   = 2;
  localparam int RESP_DEPTH = 4;
  localparam int TAG_W      = 4;
  localparam int BE_W       = DATA_W / 8;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              in_req_valid;
  logic              out_req_ready;
  logic              in_req_we;
  logic [ADDR_W-1:0] in_req_addr;
  logic [DATA_W-1:0] in_req_wdata;
  logic [BE_W-1:0]   in_req_be;
  logic [TAG_W-1:0]  in_req_tag;
  logic              out_rsp_valid;
  logic              in_rsp_ready;
  logic [DATA_W-1:0] out_rsp_data;
  logic [TAG_W-1:0]  out_rsp_tag;

  // Clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dmem_pipe #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT),
    .RESP_DEPTH(RESP_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
    .in_req_we(in_req_we), .in_req_addr(in_req_addr),
    .in_req_wdata(in_req_wdata), .in_req_be(in_req_be), .in_req_tag(in_req_tag),
    .out_rsp_valid(out_rsp_valid), .in_rsp_ready(in_rsp_ready),
    .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag)
  );

  // Scoreboard / reference model
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [DATA_W-1:0]       model_mem [2**ADDR_W];
  logic [TAG_W+DATA_W-1:0] exp_q[$];
  int                      time_q[$];

  task automatic chk(input string name, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Driver: one clock cycle; checks outputs, updates model, advances past the edge
  task automatic step(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be,
                      input logic [TAG_W-1:0] tg, input logic rr);
    logic exp_rdy, exp_v;
    logic [DATA_W-1:0] exp_d;
    logic [TAG_W-1:0]  exp_t;
    in_req_valid = v;
    in_req_we    = we;
    in_req_addr  = a;
    in_req_wdata = wd;
    in_req_be    = be;
    in_req_tag   = tg;
    in_rsp_ready = rr;
    exp_rdy = (exp_q.size() < RESP_DEPTH);
    exp_v   = (exp_q.size() > 0) && (cyc >= time_q[0] + READ_LAT);
    exp_d   = '0;
    exp_t   = '0;
    if (exp_v) begin
      exp_d = exp_q[0][DATA_W-1:0];
      exp_t = exp_q[0][TAG_W+DATA_W-1:DATA_W];
    end
    chk("req_ready", DATA_W'(out_req_ready), DATA_W'(exp_rdy));
    chk("rsp_valid", DATA_W'(out_rsp_valid), DATA_W'(exp_v));
    chk("rsp_data", out_rsp_data, exp_d);
    chk("rsp_tag", DATA_W'(out_rsp_tag), DATA_W'(exp_t));
    if (exp_v && rr) begin
      void'(exp_q.pop_front());
      void'(time_q.pop_front());
    end
    if (v && exp_rdy) begin
      if (we) begin
        for (int k = 0; k < BE_W; k++) begin
          if (be[k]) model_mem[a][8*k +: 8] = wd[8*k +: 8];
        end
      end else begin
        exp_q.push_back({tg, model_mem[a]});
        time_q.push_back(cyc);
      end
    end
    @(posedge i_clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, '0, '0, '0, '0, rr);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] tg, input logic rr);
    step(1'b1, 1'b0, a, '0, '0, tg, rr);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
    step(1'b1, 1'b1, a, wd, be, '0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1'b1);
  endtask

  task automatic do_reset();
    i_rst        = 1'b1;
    in_req_valid = 1'b0;
    in_rsp_ready = 1'b0;
    @(posedge i_clk);
    cyc++;
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    time_q.delete();
  endtask

  initial begin
    i_rst = 1'b0;
    in_req_valid = 1'b0; in_req_we = 1'b0; in_req_addr = '0; in_req_wdata = '0;
    in_req_be = '0; in_req_tag = '0; in_rsp_ready = 1'b0;
    @(posedge i_clk); #1;
    do_reset();
    chk("reset_ready", DATA_W'(out_req_ready), 1);
    chk("reset_valid", DATA_W'(out_rsp_valid), 0);
    chk("reset_data", out_rsp_data, 0);
    chk("reset_tag", DATA_W'(out_rsp_tag), 0);

    // Fill memory so any address can be read back
    for (int i = 0; i < 2**ADDR_W; i++) wr(ADDR_W'(i), $urandom, 4'hF);

    // Byte-enable merge
    wr(10'h010, 32'hAABBCCDD, 4'hF);
    wr(10'h010, 32'h11223344, 4'h3);
    rd(10'h010, 4'h1, 1'b0);
    idle(1'b0);
    chk("be_merge_valid", DATA_W'(out_rsp_valid), 1);
    chk("be_merge_data", out_rsp_data, 32'hAABB3344);
    drain();

    // Read latency
    rd(10'd5, 4'h3, 1'b1);
    chk("lat_t1_valid", DATA_W'(out_rsp_valid), 0);
    idle(1'b1);
    chk("lat_t2_valid", DATA_W'(out_rsp_valid), 1);
    chk("lat_t2_tag", DATA_W'(out_rsp_tag), 3);
    drain();

    // Back-pressure to full, then pop one to let the fifth read in
    for (int i = 0; i < RESP_DEPTH; i++) rd(ADDR_W'(32 + i), TAG_W'(i), 1'b0);
    chk("bp_full_ready", DATA_W'(out_req_ready), 0);
    rd(10'd36, 4'h4, 1'b1);
    chk("bp_pop_ready", DATA_W'(out_req_ready), 1);
    rd(10'd36, 4'h4, 1'b0);
    drain();

    // Accept and pop together at RESP_DEPTH-1 outstanding
    for (int i = 0; i < RESP_DEPTH - 1; i++) rd(ADDR_W'(40 + i), TAG_W'(8 + i), 1'b0);
    idle(1'b0);
    rd(10'd43, 4'hB, 1'b1);
    chk("simul_ready", DATA_W'(out_req_ready), 1);
    drain();

    // Read after write
    wr(10'd7, 32'hDEADBEEF, 4'hF);
    rd(10'd7, 4'h7, 1'b0);
    idle(1'b0);
    chk("raw_data", out_rsp_data, 32'hDEADBEEF);
    chk("raw_tag", DATA_W'(out_rsp_tag), 7);
    drain();

    // Reset with reads in flight
    rd(10'h010, 4'h2, 1'b1);
    rd(10'd7, 4'h5, 1'b1);
    do_reset();
    chk("midrst_ready", DATA_W'(out_req_ready), 1);
    chk("midrst_valid", DATA_W'(out_rsp_valid), 0);
    chk("midrst_data", out_rsp_data, 0);
    chk("midrst_tag", DATA_W'(out_rsp_tag), 0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    rd(10'h010, 4'h9, 1'b1);
    rd(10'd7, 4'hA, 1'b1);
    chk("midrst_mem10", out_rsp_data, 32'hAABB3344);
    idle(1'b1);
    chk("midrst_mem7", out_rsp_data, 32'hDEADBEEF);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           ADDR_W'($urandom), $urandom, BE_W'($urandom_range(0, 15)),
           TAG_W'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
